// File: rtl/rv_id_stage.sv
// rv_id_stage: RV32I decode stage with a registered ID/EX output.
// The stage decodes the instruction, resolves operands from the regfile and the
// forwarding sources, stalls on load-use, and resolves branches and jumps.
// After a taken redirect it discards the next KILL_SLOTS accepted fetches.
// Optional build macro ID_ILLEGAL_TRAP_EN: when defined, an illegal instruction
// is emitted with illegal_o set and the stage halts until flush_i. When it is
// not defined, an illegal instruction is dropped as a bubble.
module rv_id_stage #(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int KILL_SLOTS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic [4:0]              rs1_addr_o,
    output logic [4:0]              rs2_addr_o,
    input  logic [XLEN-1:0]         rs1_data_i,
    input  logic [XLEN-1:0]         rs2_data_i,
    input  logic [NUM_FWD-1:0]      fwd_wreg_i,
    input  logic [NUM_FWD-1:0]      fwd_load_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              aluop_o,
    output logic [2:0]              alusel_o,
    output logic [XLEN-1:0]         op1_o,
    output logic [XLEN-1:0]         op2_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [4:0]              wd_o,
    output logic                    wreg_o,
    output logic [XLEN-1:0]         link_addr_o,
    output logic                    branch_flag_o,
    output logic [XLEN-1:0]         branch_target_o
`ifdef ID_ILLEGAL_TRAP_EN
    , output logic                  illegal_o
`endif
);

    localparam logic [7:0] EXE_NOP_OP  = 8'h00, EXE_ADD_OP  = 8'h20, EXE_SUB_OP  = 8'h22;
    localparam logic [7:0] EXE_AND_OP  = 8'h24, EXE_OR_OP   = 8'h25, EXE_XOR_OP  = 8'h26;
    localparam logic [7:0] EXE_SLT_OP  = 8'h2A, EXE_SLTU_OP = 8'h2B, EXE_SLL_OP  = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP  = 8'h02, EXE_SRA_OP  = 8'h03, EXE_JAL_OP  = 8'h50;
    localparam logic [7:0] EXE_JALR_OP = 8'h09, EXE_BEQ_OP  = 8'h51, EXE_BNE_OP  = 8'h52;
    localparam logic [7:0] EXE_BLT_OP  = 8'h53, EXE_BGE_OP  = 8'h54, EXE_BLTU_OP = 8'h55;
    localparam logic [7:0] EXE_BGEU_OP = 8'h56, EXE_LB_OP   = 8'h60, EXE_LH_OP   = 8'h61;
    localparam logic [7:0] EXE_LW_OP   = 8'h62, EXE_LBU_OP  = 8'h63, EXE_LHU_OP  = 8'h64;
    localparam logic [7:0] EXE_SB_OP   = 8'h68, EXE_SH_OP   = 8'h69, EXE_SW_OP   = 8'h6A;
    localparam logic [2:0] EXE_RES_NOP = 3'b000, EXE_RES_LOGIC = 3'b001, EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100, EXE_RES_JUMP_BRANCH = 3'b110;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;
    localparam int CW = (KILL_SLOTS < 1) ? 1 : $clog2(KILL_SLOTS + 1);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_KILL = 2'd1, ST_HALT = 2'd2} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_valid, r_wreg, r_bflag;
    logic [7:0]      r_aluop;
    logic [2:0]      r_alusel;
    logic [4:0]      r_wd;
    logic [XLEN-1:0] r_op1, r_op2, r_imm, r_link, r_btarget;
`ifdef ID_ILLEGAL_TRAP_EN
    logic            r_illegal;
`endif

    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_wd;
    logic [7:0]      w_aluop;
    logic [2:0]      w_alusel;
    logic            w_re1, w_re2, w_wreg, w_illegal, w_op1_pc;
    logic            w_is_br, w_is_jal, w_is_jalr, w_cond, w_taken;
    logic            w_hazard, w_in_ready, w_fire, w_unused;
    logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_op1, w_op2, w_target, w_link;

    assign w_opc      = inst_i[6:0];
    assign w_f3       = inst_i[14:12];
    assign w_f7       = inst_i[31:25];
    assign w_rs1      = inst_i[19:15];
    assign w_rs2      = inst_i[24:20];
    assign rs1_addr_o = w_rs1;
    assign rs2_addr_o = w_rs2;
    assign w_unused   = ^fwd_load_i;

    // Instruction decode: ALU op, result select, read enables, immediate, legality.
    always_comb begin
        w_aluop = EXE_NOP_OP; w_alusel = EXE_RES_NOP; w_imm = {XLEN{1'b0}};
        w_re1 = 1'b0; w_re2 = 1'b0; w_wreg = 1'b0; w_illegal = 1'b0; w_op1_pc = 1'b0;
        w_is_br = 1'b0; w_is_jal = 1'b0; w_is_jalr = 1'b0;
        case (w_opc)
            7'b0110111, 7'b0010111: begin
                w_aluop = EXE_ADD_OP; w_alusel = EXE_RES_ARITH; w_wreg = 1'b1;
                w_imm = XLEN'($signed({inst_i[31:12], 12'b0}));
                w_op1_pc = inst_i[5] ? 1'b0 : 1'b1;
            end
            7'b1101111: begin
                w_aluop = EXE_JAL_OP; w_alusel = EXE_RES_JUMP_BRANCH; w_wreg = 1'b1;
                w_is_jal = 1'b1; w_op1_pc = 1'b1;
                w_imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
            end
            7'b1100111: begin
                w_aluop = EXE_JALR_OP; w_alusel = EXE_RES_JUMP_BRANCH; w_wreg = 1'b1;
                w_re1 = 1'b1; w_is_jalr = 1'b1; w_imm = XLEN'($signed(inst_i[31:20]));
                w_illegal = (w_f3 != 3'b000);
            end
            7'b1100011: begin
                w_alusel = EXE_RES_JUMP_BRANCH; w_re1 = 1'b1; w_re2 = 1'b1; w_is_br = 1'b1;
                w_imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
                case (w_f3)
                    3'b000:  w_aluop = EXE_BEQ_OP;
                    3'b001:  w_aluop = EXE_BNE_OP;
                    3'b100:  w_aluop = EXE_BLT_OP;
                    3'b101:  w_aluop = EXE_BGE_OP;
                    3'b110:  w_aluop = EXE_BLTU_OP;
                    3'b111:  w_aluop = EXE_BGEU_OP;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                w_alusel = EXE_RES_LOAD_STORE; w_re1 = 1'b1; w_wreg = 1'b1;
                w_imm = XLEN'($signed(inst_i[31:20]));
                case (w_f3)
                    3'b000:  w_aluop = EXE_LB_OP;
                    3'b001:  w_aluop = EXE_LH_OP;
                    3'b010:  w_aluop = EXE_LW_OP;
                    3'b100:  w_aluop = EXE_LBU_OP;
                    3'b101:  w_aluop = EXE_LHU_OP;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                w_alusel = EXE_RES_LOAD_STORE; w_re1 = 1'b1; w_re2 = 1'b1;
                w_imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                case (w_f3)
                    3'b000:  w_aluop = EXE_SB_OP;
                    3'b001:  w_aluop = EXE_SH_OP;
                    3'b010:  w_aluop = EXE_SW_OP;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                w_re1 = 1'b1; w_wreg = 1'b1; w_imm = XLEN'($signed(inst_i[31:20]));
                case (w_f3)
                    3'b000: begin w_aluop = EXE_ADD_OP;  w_alusel = EXE_RES_ARITH; end
                    3'b010: begin w_aluop = EXE_SLT_OP;  w_alusel = EXE_RES_ARITH; end
                    3'b011: begin w_aluop = EXE_SLTU_OP; w_alusel = EXE_RES_ARITH; end
                    3'b100: begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
                    3'b110: begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
                    3'b111: begin w_aluop = EXE_AND_OP;  w_alusel = EXE_RES_LOGIC; end
                    3'b001: begin
                        w_aluop = EXE_SLL_OP; w_alusel = EXE_RES_SHIFT;
                        w_imm = XLEN'(inst_i[24:20]); w_illegal = (w_f7 != 7'b0000000);
                    end
                    3'b101: begin
                        w_aluop = (w_f7 == 7'b0100000) ? EXE_SRA_OP : EXE_SRL_OP;
                        w_alusel = EXE_RES_SHIFT; w_imm = XLEN'(inst_i[24:20]);
                        w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0110011: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_wreg = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_000: begin w_aluop = EXE_ADD_OP;  w_alusel = EXE_RES_ARITH; end
                    10'b0100000_000: begin w_aluop = EXE_SUB_OP;  w_alusel = EXE_RES_ARITH; end
                    10'b0000000_001: begin w_aluop = EXE_SLL_OP;  w_alusel = EXE_RES_SHIFT; end
                    10'b0000000_010: begin w_aluop = EXE_SLT_OP;  w_alusel = EXE_RES_ARITH; end
                    10'b0000000_011: begin w_aluop = EXE_SLTU_OP; w_alusel = EXE_RES_ARITH; end
                    10'b0000000_100: begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
                    10'b0000000_101: begin w_aluop = EXE_SRL_OP;  w_alusel = EXE_RES_SHIFT; end
                    10'b0100000_101: begin w_aluop = EXE_SRA_OP;  w_alusel = EXE_RES_SHIFT; end
                    10'b0000000_110: begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
                    10'b0000000_111: begin w_aluop = EXE_AND_OP;  w_alusel = EXE_RES_LOGIC; end
                    default:         w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Operand resolution: lowest-index matching source wins; x0 never forwards.
    always_comb begin
        w_rs1_val = rs1_data_i;
        w_rs2_val = rs2_data_i;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            w_rs1_val = (fwd_wreg_i[k] && (fwd_wd_i[k*5 +: 5] == w_rs1)) ? fwd_wdata_i[k*XLEN +: XLEN] : w_rs1_val;
            w_rs2_val = (fwd_wreg_i[k] && (fwd_wd_i[k*5 +: 5] == w_rs2)) ? fwd_wdata_i[k*XLEN +: XLEN] : w_rs2_val;
        end
        w_op1 = w_re1 ? ((w_rs1 == 5'd0) ? {XLEN{1'b0}} : w_rs1_val)
                      : (w_op1_pc ? pc_i : {XLEN{1'b0}});
        w_op2 = w_re2 ? ((w_rs2 == 5'd0) ? {XLEN{1'b0}} : w_rs2_val) : w_imm;
    end

    // Branch condition, redirect target and link address.
    always_comb begin
        case (w_f3)
            3'b000:  w_cond = (w_op1 == w_op2);
            3'b001:  w_cond = (w_op1 != w_op2);
            3'b100:  w_cond = ($signed(w_op1) <  $signed(w_op2));
            3'b101:  w_cond = ($signed(w_op1) >= $signed(w_op2));
            3'b110:  w_cond = (w_op1 <  w_op2);
            3'b111:  w_cond = (w_op1 >= w_op2);
            default: w_cond = 1'b0;
        endcase
        w_taken  = !w_illegal && (w_is_jal || w_is_jalr || (w_is_br && w_cond));
        w_target = w_is_jalr ? ((w_op1 + w_imm) & {{(XLEN-1){1'b1}}, 1'b0}) : (pc_i + w_imm);
        w_link   = (w_is_jal || w_is_jalr) ? (pc_i + XLEN'(4)) : {XLEN{1'b0}};
    end

    assign w_wd       = w_wreg ? inst_i[11:7] : 5'd0;
    assign w_hazard   = fwd_load_i[0] && fwd_wreg_i[0] &&
                        ((w_re1 && (w_rs1 != 5'd0) && (fwd_wd_i[4:0] == w_rs1)) ||
                         (w_re2 && (w_rs2 != 5'd0) && (fwd_wd_i[4:0] == w_rs2)));
    assign w_in_ready = (!r_valid || out_ready_i) && !w_hazard && (r_state != ST_HALT);
    assign w_fire     = in_valid_i && w_in_ready;

    // Control FSM (RUN/KILL/HALT) together with the ID/EX output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN; r_cnt <= {CW{1'b0}}; r_valid <= 1'b0; r_bflag <= 1'b0;
            r_aluop <= EXE_NOP_OP; r_alusel <= EXE_RES_NOP; r_wd <= 5'd0; r_wreg <= 1'b0;
            r_op1 <= {XLEN{1'b0}}; r_op2 <= {XLEN{1'b0}}; r_imm <= {XLEN{1'b0}};
            r_link <= {XLEN{1'b0}}; r_btarget <= {XLEN{1'b0}};
`ifdef ID_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (flush_i) begin
            r_valid <= 1'b0; r_bflag <= 1'b0; r_state <= ST_RUN; r_cnt <= {CW{1'b0}};
        end else begin
            r_bflag <= 1'b0;
            if (w_fire) begin
                case (r_state)
                    ST_KILL: begin
                        // Wrong-path slot: consumed and dropped, never redirects.
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt - CW'(1);
                        r_state <= (r_cnt == CW'(1)) ? ST_RUN : ST_KILL;
                    end
                    ST_RUN: begin
                        if (w_illegal) begin
`ifdef ID_ILLEGAL_TRAP_EN
                            r_valid <= 1'b1; r_illegal <= 1'b1; r_aluop <= EXE_NOP_OP;
                            r_alusel <= EXE_RES_NOP; r_wreg <= 1'b0; r_wd <= 5'd0;
                            r_op1 <= w_op1; r_op2 <= w_op2; r_imm <= w_imm;
                            r_link <= {XLEN{1'b0}}; r_state <= ST_HALT;
`else
                            r_valid <= 1'b0;
`endif
                        end else begin
                            r_valid <= 1'b1; r_aluop <= w_aluop; r_alusel <= w_alusel;
                            r_wreg <= w_wreg; r_wd <= w_wd; r_op1 <= w_op1; r_op2 <= w_op2;
                            r_imm <= w_imm; r_link <= w_link;
`ifdef ID_ILLEGAL_TRAP_EN
                            r_illegal <= 1'b0;
`endif
                            if (w_taken) begin
                                r_bflag <= 1'b1; r_btarget <= w_target;
                                if (KILL_SLOTS > 0) begin
                                    r_state <= ST_KILL; r_cnt <= CW'(KILL_SLOTS);
                                end else begin
                                    r_state <= ST_RUN;
                                end
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end
                    end
                    default: r_valid <= 1'b0;
                endcase
            end else if (out_ready_i) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign in_ready_o      = w_in_ready;
    assign out_valid_o     = r_valid;
    assign aluop_o         = r_aluop;
    assign alusel_o        = r_alusel;
    assign op1_o           = r_op1;
    assign op2_o           = r_op2;
    assign imm_o           = r_imm;
    assign wd_o            = r_wd;
    assign wreg_o          = r_wreg;
    assign link_addr_o     = r_link;
    assign branch_flag_o   = r_bflag;
    assign branch_target_o = r_btarget;
`ifdef ID_ILLEGAL_TRAP_EN
    assign illegal_o       = r_illegal;
`endif

endmodule
